// File: rtl/aud_pkg.sv
// aud_pkg
// Shared definitions for the audio playback path: audio source selection
// codes, default memory geometries for each source, and the state encoding
// of the sample-fetch FSM.
// Ports: none (package).
package aud_pkg;

  typedef enum logic [1:0] {
    SRC_SIN   = 2'd0,
    SRC_FLASH = 2'd1,
    SRC_SDRAM = 2'd2,
    SRC_SRAM  = 2'd3
  } aud_src_e;

  localparam int FLASH_ADDR_W   = 22;
  localparam int FLASH_DATA_W   = 8;
  localparam int FLASH_DATA_NUM = 2097152;

  localparam int SDRAM_ADDR_W   = 22;
  localparam int SDRAM_DATA_W   = 16;
  localparam int SDRAM_DATA_NUM = 4194304;

  localparam int SRAM_ADDR_W    = 18;
  localparam int SRAM_DATA_W    = 16;
  localparam int SRAM_DATA_NUM  = 262144;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/aud_sync_fifo.sv
// aud_sync_fifo
// Single-clock FIFO with occupancy count and synchronous flush. Push while
// full and pop while empty are ignored. Flush has priority over push/pop.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_flush           empty the FIFO on the next edge
//   i_push, i_data    write request and write word
//   i_pop             read request (head advances on the next edge)
//   o_head            word at the head of the FIFO
//   o_full, o_empty   occupancy flags
//   o_level           number of stored words
module aud_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == (PW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + (PW+1)'(1);
        2'b01:   r_level <= r_level - (PW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/aud_sample_fetch.sv
// aud_sample_fetch
// Prefetches PCM words sequentially from a fixed-latency SRAM-style port into
// a small FIFO and hands one word to the DAC serializer per sample request.
// Flags underrun when a request finds no data (or fetching is disabled).
// Ports:
//   iCLK_18_4, iRST      clock, asynchronous active-high reset
//   iEnable              1 = fetch and serve samples
//   oMEM_ADDR, oMEM_RD   read address (held issue..capture) and read strobe
//   iMEM_DATA            read data, valid RD_LATENCY cycles after oMEM_RD
//   iSample_Req          one-cycle sample request from the serializer
//   oSample              last popped sample
//   oSample_Valid        one-cycle pulse per successful pop
//   oUnderrun            sticky underrun flag, cleared by iUnderrun_Clr
//   oLevel               FIFO occupancy
module aud_sample_fetch
  import aud_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int DATA_WIDTH = SRAM_DATA_W,
  parameter int DATA_NUM   = SRAM_DATA_NUM,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                          iCLK_18_4,
  input  logic                          iRST,
  input  logic                          iEnable,
  output logic [ADDR_WIDTH-1:0]         oMEM_ADDR,
  output logic                          oMEM_RD,
  input  logic [DATA_WIDTH-1:0]         iMEM_DATA,
  input  logic                          iSample_Req,
  output logic [DATA_WIDTH-1:0]         oSample,
  output logic                          oSample_Valid,
  output logic                          oUnderrun,
  input  logic                          iUnderrun_Clr,
  output logic [$clog2(FIFO_DEPTH):0]   oLevel
);

  localparam int LAT_W = $clog2(RD_LATENCY + 1);

  fetch_state_e                  r_state;
  fetch_state_e                  w_state_nxt;
  logic [LAT_W-1:0]              r_lat_cnt;
  logic [ADDR_WIDTH-1:0]         r_addr;
  logic [DATA_WIDTH-1:0]         r_sample_p1;
  logic                          r_sample_vld_p1;
  logic                          r_underrun;

  logic                          w_lat_done;
  logic                          w_issue;
  logic                          w_capture;
  logic                          w_flush;
  logic                          w_pop;
  logic                          w_underrun_set;
  logic                          w_full;
  logic                          w_empty;
  logic [DATA_WIDTH-1:0]         w_head;
  logic [$clog2(FIFO_DEPTH):0]   w_level;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(DATA_NUM - 1)) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  assign w_lat_done = (r_lat_cnt == LAT_W'(RD_LATENCY));
  // Flushing whenever the FSM is (or is about to be) idle keeps the FIFO and
  // address clean on every entry to IDLE without a separate entry detector.
  assign w_flush    = (w_state_nxt == IDLE);
  // A disabled block serves nothing, so a request then counts as empty.
  assign w_pop          = iSample_Req && iEnable && !w_empty;
  assign w_underrun_set = iSample_Req && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (iEnable) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!iEnable) begin
          w_state_nxt = IDLE;
        end else if (!w_full) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_lat_done) begin
          if (iEnable) begin
            w_capture   = 1'b1;
            w_state_nxt = ISSUE;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (!iEnable) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Let the outstanding read complete on schedule; its data is dropped.
        if (w_lat_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK_18_4 or posedge iRST) begin
    if (iRST) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_addr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_lat_cnt <= LAT_W'(1);
      end else if (r_state == WAIT || r_state == DRAIN) begin
        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
      end
      if (w_flush) begin
        r_addr <= '0;
      end else if (w_capture) begin
        r_addr <= next_addr(r_addr);
      end
    end
  end

  // ---- stage p1: registered sample output and status ----
  always_ff @(posedge iCLK_18_4 or posedge iRST) begin
    if (iRST) begin
      r_sample_p1     <= '0;
      r_sample_vld_p1 <= 1'b0;
      r_underrun      <= 1'b0;
    end else begin
      r_sample_vld_p1 <= w_pop;
      if (w_pop) r_sample_p1 <= w_head;
      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end else if (iUnderrun_Clr) begin
        r_underrun <= 1'b0;
      end
    end
  end

  aud_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .i_clk   (iCLK_18_4),
    .i_rst   (iRST),
    .i_flush (w_flush),
    .i_push  (w_capture),
    .i_data  (iMEM_DATA),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign oMEM_ADDR     = r_addr;
  assign oMEM_RD       = w_issue;
  assign oSample       = r_sample_p1;
  assign oSample_Valid = r_sample_vld_p1;
  assign oUnderrun     = r_underrun;
  assign oLevel        = w_level;

endmodule

// File: tb/tb_aud_sample_fetch.sv
module tb_aud_sample_fetch;

  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int DN  = 16;
  localparam int FD  = 8;
  localparam int LAT = 2;
  localparam int LW  = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          req = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] mem_data = 16'hDEAD;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] sample;
  logic          sample_vld;
  logic          underrun;
  logic [LW-1:0] level;

  aud_sample_fetch #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DATA_NUM   (DN),
    .FIFO_DEPTH (FD),
    .RD_LATENCY (LAT)
  ) dut (
    .iCLK_18_4     (clk),
    .iRST          (rst),
    .iEnable       (en),
    .oMEM_ADDR     (mem_addr),
    .oMEM_RD       (mem_rd),
    .iMEM_DATA     (mem_data),
    .iSample_Req   (req),
    .oSample       (sample),
    .oSample_Valid (sample_vld),
    .oUnderrun     (underrun),
    .iUnderrun_Clr (clr),
    .oLevel        (level)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q  [$];
  logic [AW-1:0] rd_log [$];
  int            next_val    = 0;
  logic [DW-1:0] last_sample = '0;

  // Memory model: data = address, presented only for the edge that ends
  // the cycle RD_LATENCY after the strobe; otherwise a poison value.
  logic          pipe_v [0:LAT] = '{default: 1'b0};
  logic [AW-1:0] pipe_a [0:LAT] = '{default: '0};
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = mem_rd;
    pipe_a[0] = mem_addr;
    if (mem_rd) rd_log.push_back(mem_addr);
    mem_data = pipe_v[LAT] ? DW'(pipe_a[LAT]) : 16'hDEAD;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle request; scoreboard entry pushed when a pop is expected,
  // popped when the DUT shows its valid pulse one cycle later.
  task automatic req_pulse(input bit ok, input bit with_clr = 1'b0);
    req = 1'b1;
    clr = with_clr;
    if (ok) begin
      exp_q.push_back(DW'(next_val % DN));
      next_val++;
    end
    tick(1);
    req = 1'b0;
    clr = 1'b0;
    chk("sample_valid", 32'(sample_vld), 32'(ok));
    if (sample_vld) begin
      if (exp_q.size() == 0) begin
        chk("sample_unexpected", 32'(sample), 32'hFFFF_FFFF);
      end else begin
        last_sample = exp_q.pop_front();
        chk("sample_data", 32'(sample), 32'(last_sample));
      end
    end else begin
      chk("sample_hold", 32'(sample), 32'(last_sample));
    end
  endtask

  typedef struct {
    int            cyc;
    logic          en;
    logic          rd;
    logic [AW-1:0] addr;
    logic [LW-1:0] lvl;
  } vec_t;

  vec_t tv [11];

  initial begin
    int cyc;
    int rdcnt;

    tv[0]  = '{1,  1'b1, 1'b1, 18'd0, 4'd0};
    tv[1]  = '{2,  1'b1, 1'b0, 18'd0, 4'd0};
    tv[2]  = '{3,  1'b1, 1'b0, 18'd0, 4'd0};
    tv[3]  = '{4,  1'b1, 1'b1, 18'd1, 4'd1};
    tv[4]  = '{5,  1'b1, 1'b0, 18'd1, 4'd1};
    tv[5]  = '{7,  1'b1, 1'b1, 18'd2, 4'd2};
    tv[6]  = '{13, 1'b1, 1'b1, 18'd4, 4'd4};
    tv[7]  = '{22, 1'b1, 1'b1, 18'd7, 4'd7};
    tv[8]  = '{24, 1'b1, 1'b0, 18'd7, 4'd7};
    tv[9]  = '{25, 1'b1, 1'b0, 18'd8, 4'd8};
    tv[10] = '{30, 1'b1, 1'b0, 18'd8, 4'd8};

    // Reset values
    tick(2);
    chk("rst_addr",     32'(mem_addr),   32'd0);
    chk("rst_rd",       32'(mem_rd),     32'd0);
    chk("rst_sample",   32'(sample),     32'd0);
    chk("rst_valid",    32'(sample_vld), 32'd0);
    chk("rst_underrun", 32'(underrun),   32'd0);
    chk("rst_level",    32'(level),      32'd0);
    rst = 1'b0;
    tick(1);
    chk("idle_rd", 32'(mem_rd), 32'd0);

    // Fill from empty: table of per-cycle expectations after enable
    en = 1'b1;
    cyc = 0;
    rdcnt = 0;
    chk("rd_before_issue", 32'(mem_rd), 32'd0);
    for (int i = 0; i < 11; i++) begin
      en = tv[i].en;
      while (cyc < tv[i].cyc) begin
        tick(1);
        cyc++;
        rdcnt += int'(mem_rd);
      end
      chk($sformatf("fill_rd[c%0d]", cyc),    32'(mem_rd),   32'(tv[i].rd));
      chk($sformatf("fill_addr[c%0d]", cyc),  32'(mem_addr), 32'(tv[i].addr));
      chk($sformatf("fill_level[c%0d]", cyc), 32'(level),    32'(tv[i].lvl));
    end
    while (cyc < 40) begin
      tick(1);
      cyc++;
      rdcnt += int'(mem_rd);
    end
    chk("fill_rd_count", 32'(rdcnt), 32'd8);

    // Three spaced requests from full, then steady requests across the wrap
    rd_log.delete();
    for (int i = 0; i < 3; i++) begin
      req_pulse(1'b1);
      chk("pop_level", 32'(level), 32'(FD - 1));
      chk("refill_rd", 32'(mem_rd), 32'd1);
      chk("refill_addr", 32'(mem_addr), 32'(8 + i));
      tick(1);
      chk("valid_one_cycle", 32'(sample_vld), 32'd0);
      tick(8);
      chk("refill_level", 32'(level), 32'(FD));
    end
    for (int i = 0; i < 15; i++) begin
      req_pulse(1'b1);
      tick(2);
    end
    tick(10);
    chk("wrap_level", 32'(level), 32'(FD));
    chk("wrap_rd_count", 32'(rd_log.size()), 32'd18);
    for (int i = 0; i < rd_log.size(); i++)
      chk($sformatf("rd_addr[%0d]", i), 32'(rd_log[i]), 32'((8 + i) % DN));

    // Disable one cycle after a strobe; request while disabled
    req_pulse(1'b1);
    chk("drain_issue_rd", 32'(mem_rd), 32'd1);
    chk("drain_issue_addr", 32'(mem_addr), 32'd10);
    tick(1);
    en = 1'b0;
    req_pulse(1'b0);
    chk("underrun_disabled", 32'(underrun), 32'd1);
    chk("drain_level", 32'(level), 32'(FD - 1));
    tick(1);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_addr", 32'(mem_addr), 32'd0);
    chk("flush_rd", 32'(mem_rd), 32'd0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("underrun_clear", 32'(underrun), 32'd0);
    tick(3);

    // Re-enable with a request at level 0
    en = 1'b1;
    req_pulse(1'b0);
    chk("empty_underrun", 32'(underrun), 32'd1);
    chk("reenable_rd", 32'(mem_rd), 32'd1);
    chk("reenable_addr", 32'(mem_addr), 32'd0);
    chk("reenable_level", 32'(level), 32'd0);
    tick(1);
    chk("underrun_sticky", 32'(underrun), 32'd1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("underrun_clear2", 32'(underrun), 32'd0);
    // Capture cycle at level 0: request fails, push kept, set beats clear
    req_pulse(1'b0, 1'b1);
    chk("same_cycle_underrun", 32'(underrun), 32'd1);
    chk("same_cycle_level", 32'(level), 32'd1);
    chk("next_issue_addr", 32'(mem_addr), 32'd1);

    // Asynchronous reset in the middle of a read
    tick(1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_addr",     32'(mem_addr),   32'd0);
    chk("arst_rd",       32'(mem_rd),     32'd0);
    chk("arst_sample",   32'(sample),     32'd0);
    chk("arst_valid",    32'(sample_vld), 32'd0);
    chk("arst_underrun", 32'(underrun),   32'd0);
    chk("arst_level",    32'(level),      32'd0);
    #1;
    rst = 1'b0;
    last_sample = '0;
    tick(1);
    chk("post_rst_rd", 32'(mem_rd), 32'd1);
    chk("post_rst_addr", 32'(mem_addr), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
